// File: rtl/code_sender.sv
// code_sender: bit-serial unlock-code transmitter.
// Accepts a CODE_LEN-bit code on start. It shifts the code out MSB-first on
// d_out, holding each bit for BIT_CYCLES clocks. It then waits up to
// ACK_TIMEOUT cycles for door_open, and retries up to MAX_RETRY times after a
// 2*BIT_CYCLES quiet gap.
// Ports:
//   clk        rising-edge clock
//   reset      asynchronous active-low reset
//   start      transaction request, sampled only in IDLE
//   code_in    code to send, latched when start is accepted
//   door_open  lock feedback, sampled only in WAIT_ACK
//   d_out      registered serial code
//   busy       high in every state except IDLE
//   done       one-cycle completion pulse
//   unlocked   result; valid with done, held until the next accepted start
module code_sender #(
  parameter int CODE_LEN    = 6,
  parameter int BIT_CYCLES  = 1,
  parameter int ACK_TIMEOUT = 8,
  parameter int MAX_RETRY   = 2
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic [CODE_LEN-1:0] code_in,
  input  logic                door_open,
  output logic                d_out,
  output logic                busy,
  output logic                done,
  output logic                unlocked
);

  localparam int CYC_MAX = (ACK_TIMEOUT > 2*BIT_CYCLES) ? ACK_TIMEOUT : 2*BIT_CYCLES;
  localparam int CW      = $clog2(CYC_MAX + 1);
  localparam int BW      = $clog2(CODE_LEN);
  localparam int RW      = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

  localparam logic [CW-1:0] BIT_LAST  = CW'(BIT_CYCLES - 1);
  localparam logic [CW-1:0] ACK_LAST  = CW'(ACK_TIMEOUT - 1);
  localparam logic [CW-1:0] GAP_LAST  = CW'(2*BIT_CYCLES - 1);
  localparam logic [BW-1:0] IDX_LAST  = BW'(CODE_LEN - 1);
  localparam logic [RW-1:0] RETRY_MAX = RW'(MAX_RETRY);

  typedef enum logic [2:0] {IDLE, SEND, WAIT_ACK, GAP, DONE} state_t;

  state_t              state_q, state_d;
  logic [CODE_LEN-1:0] code_q, code_d;
  logic [CODE_LEN-1:0] shift_q, shift_d;
  logic [BW-1:0]       bit_q, bit_d;
  logic [CW-1:0]       cyc_q, cyc_d;
  logic [RW-1:0]       retry_q, retry_d;
  logic                d_out_q, d_out_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                unlocked_q, unlocked_d;

  // Outputs are registered one cycle ahead: d_out_d always carries the bit
  // that belongs on the wire in the state being entered.
  always_comb begin
    state_d    = state_q;
    code_d     = code_q;
    shift_d    = shift_q;
    bit_d      = bit_q;
    cyc_d      = cyc_q;
    retry_d    = retry_q;
    d_out_d    = 1'b0;
    busy_d     = busy_q;
    done_d     = 1'b0;
    unlocked_d = unlocked_q;
    case (state_q)
      IDLE: begin
        busy_d = 1'b0;
        if (start) begin
          code_d     = code_in;
          shift_d    = code_in;
          bit_d      = '0;
          cyc_d      = '0;
          retry_d    = '0;
          unlocked_d = 1'b0;
          d_out_d    = code_in[CODE_LEN-1];
          busy_d     = 1'b1;
          state_d    = SEND;
        end
      end
      SEND: begin
        if (cyc_q == BIT_LAST) begin
          cyc_d   = '0;
          shift_d = {shift_q[CODE_LEN-2:0], 1'b0};
          if (bit_q == IDX_LAST) begin
            bit_d   = '0;
            state_d = WAIT_ACK;
          end else begin
            bit_d   = bit_q + 1'b1;
            d_out_d = shift_q[CODE_LEN-2];  // next bit after the shift
          end
        end else begin
          cyc_d   = cyc_q + 1'b1;
          d_out_d = shift_q[CODE_LEN-1];
        end
      end
      WAIT_ACK: begin
        // door_open is checked before the timeout so success wins on the last cycle
        if (door_open) begin
          cyc_d      = '0;
          unlocked_d = 1'b1;
          done_d     = 1'b1;
          state_d    = DONE;
        end else if (cyc_q == ACK_LAST) begin
          cyc_d = '0;
          if (retry_q == RETRY_MAX) begin
            unlocked_d = 1'b0;
            done_d     = 1'b1;
            state_d    = DONE;
          end else begin
            retry_d = retry_q + 1'b1;
            state_d = GAP;
          end
        end else begin
          cyc_d = cyc_q + 1'b1;
        end
      end
      GAP: begin
        if (cyc_q == GAP_LAST) begin
          // retries resend the latched code, never the live code_in
          shift_d = code_q;
          d_out_d = code_q[CODE_LEN-1];
          cyc_d   = '0;
          bit_d   = '0;
          state_d = SEND;
        end else begin
          cyc_d = cyc_q + 1'b1;
        end
      end
      DONE: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      code_q     <= '0;
      shift_q    <= '0;
      bit_q      <= '0;
      cyc_q      <= '0;
      retry_q    <= '0;
      d_out_q    <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      unlocked_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      code_q     <= code_d;
      shift_q    <= shift_d;
      bit_q      <= bit_d;
      cyc_q      <= cyc_d;
      retry_q    <= retry_d;
      d_out_q    <= d_out_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      unlocked_q <= unlocked_d;
    end
  end

  assign d_out    = d_out_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign unlocked = unlocked_q;

endmodule

// File: tb/tb_code_sender.sv
// Directed bench for code_sender. Inputs change on the falling edge, so the
// value applied at the negedge of "cycle c" is sampled at the rising edge that
// ends cycle c, and outputs read at that negedge are the cycle-c outputs.
module tb_code_sender;

  logic       clk = 1'b0;
  logic       reset;
  logic       start, door_open;
  logic [5:0] code_in;
  logic       d_out, busy, done, unlocked;
  logic       start3, door3;
  logic [5:0] code3;
  logic       d_out3, busy3, done3, unlocked3;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  code_sender u_dut (
    .clk(clk), .reset(reset), .start(start), .code_in(code_in),
    .door_open(door_open), .d_out(d_out), .busy(busy), .done(done),
    .unlocked(unlocked)
  );

  code_sender #(.BIT_CYCLES(3)) u_dut3 (
    .clk(clk), .reset(reset), .start(start3), .code_in(code3),
    .door_open(door3), .d_out(d_out3), .busy(busy3), .done(done3),
    .unlocked(unlocked3)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n = 1);
    repeat (n) @(negedge clk);
  endtask

  // Ends at the negedge of cycle 1 with start dropped.
  task automatic begin_txn(input logic [5:0] c);
    start   = 1'b1;
    code_in = c;
    cyc();
    start = 1'b0;
  endtask

  // Captures d_out over six consecutive cycles starting with the current one.
  task automatic grab6(output logic [5:0] v);
    v[5] = d_out;
    for (int k = 1; k < 6; k++) begin
      cyc();
      v[5-k] = d_out;
    end
  endtask

  initial begin
    logic [5:0]  v, v2;
    logic [47:1] dv, de, dn;
    logic [19:1] d3v, d3e;
    reset = 1'b0; start = 1'b0; door_open = 1'b0; code_in = '0;
    start3 = 1'b0; door3 = 1'b0; code3 = '0;
    cyc(2);
    chk("rst_outs", {d_out, busy, done, unlocked}, 4'b0000);
    reset = 1'b1;
    cyc();

    // success on the first attempt
    begin_txn(6'b101010);
    chk("t1_busy_c1", busy, 1'b1);
    grab6(v);
    chk("t1_burst", v, 6'b101010);
    cyc();                               // cycle 7
    chk("t1_dout_c7", {d_out, done}, 2'b00);
    door_open = 1'b1;
    cyc();                               // cycle 8
    door_open = 1'b0;
    chk("t1_done_c8", {done, unlocked, busy}, 3'b111);
    cyc();                               // cycle 9
    chk("t1_idle_c9", {busy, done, unlocked}, 3'b001);

    // asynchronous reset must clear the held unlocked result
    #1 reset = 1'b0;
    #1 chk("rst_unlocked", unlocked, 1'b0);
    cyc();
    reset = 1'b1;
    cyc();

    // total failure: three bursts, two gaps, done at 47
    begin_txn(6'b110000);
    dv[1] = d_out; dn[1] = done;
    for (int c = 2; c <= 47; c++) begin
      cyc();
      dv[c] = d_out; dn[c] = done;
    end
    de = '0;
    for (int c = 1; c <= 46; c++) begin
      int off;
      off = (c - 1) % 16;
      if (off < 2) de[c] = 1'b1;         // 110000: only the top two bits are set
    end
    chk("t2_dout_1_46", dv[46:1], de[46:1]);
    chk("t2_nodone_1_46", dn[46:1], 46'd0);
    chk("t2_done_c47", {done, unlocked, busy}, 3'b101);
    cyc();
    chk("t2_idle_c48", {busy, done}, 2'b00);
    cyc();

    // success on the first retry
    begin_txn(6'b011011);
    code_in = 6'b111111;
    cyc(16);                             // cycle 17
    grab6(v);
    chk("t3_retry_burst", v, 6'b011011);
    cyc();                               // cycle 23
    door_open = 1'b1;
    chk("t3_nodone_c23", done, 1'b0);
    cyc();                               // cycle 24
    door_open = 1'b0;
    chk("t3_done_c24", {done, unlocked}, 2'b11);
    cyc();

    // start while busy and code_in changes are ignored
    start = 1'b1; code_in = 6'b100110;
    cyc();                               // cycle 1
    start = 1'b0;
    v[5] = d_out;
    cyc();                               // cycle 2
    code_in = 6'b011001;
    v[4] = d_out;
    cyc();                               // cycle 3
    start = 1'b1;
    v[3] = d_out;
    cyc();                               // cycle 4
    start = 1'b0;
    v[2] = d_out;
    cyc(); v[1] = d_out;
    cyc(); v[0] = d_out;                 // cycle 6
    chk("t4_burst", v, 6'b100110);
    cyc(4);                              // cycle 10
    start = 1'b1;
    chk("t4_busy_c10", busy, 1'b1);
    cyc();
    start = 1'b0;
    cyc(6);                              // cycle 17
    grab6(v2);
    chk("t4_retry_burst", v2, 6'b100110);
    cyc();                               // cycle 23
    door_open = 1'b1;
    cyc();                               // cycle 24
    door_open = 1'b0;
    chk("t4_done_c24", {done, unlocked}, 2'b11);
    cyc();

    // reset mid-transaction aborts immediately
    begin_txn(6'b111111);
    cyc(3);                              // cycle 4
    chk("t5_pre_rst", {d_out, busy}, 2'b11);
    #1 reset = 1'b0;
    #1 chk("t5_rst_outs", {d_out, busy, done, unlocked}, 4'b0000);
    cyc(2);
    chk("t5_no_done", done, 1'b0);
    reset = 1'b1;
    cyc();
    begin_txn(6'b101101);
    grab6(v);
    chk("t5_burst", v, 6'b101101);
    cyc();
    door_open = 1'b1;
    cyc();                               // cycle 8
    door_open = 1'b0;
    chk("t5_done_c8", {done, unlocked}, 2'b11);
    cyc();

    // BIT_CYCLES=3 instance: bits held three clocks, WAIT_ACK at 19
    start3 = 1'b1; code3 = 6'b100001;
    cyc();
    start3 = 1'b0;
    d3v[1] = d_out3;
    for (int c = 2; c <= 19; c++) begin
      cyc();
      d3v[c] = d_out3;
    end
    for (int c = 1; c <= 19; c++)
      d3e[c] = (c <= 3) || (c >= 16 && c <= 18);
    chk("t6_dout_1_19", d3v, d3e);
    chk("t6_busy_c19", {busy3, done3}, 2'b10);
    door3 = 1'b1;                        // seen in the first WAIT_ACK cycle
    cyc();                               // cycle 20
    door3 = 1'b0;
    chk("t6_done_c20", {done3, unlocked3}, 2'b11);
    cyc();
    chk("t6_idle_c21", busy3, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/code_sender.md
# code_sender

Bit-serial unlock-code transmitter: the sending end of the serial digital-lock interface. On a start request it latches a CODE_LEN-bit code and shifts it out MSB-first on `d_out`, one bit per BIT_CYCLES clocks. It then watches the lock's `door_open` feedback and retries on timeout up to MAX_RETRY times. It sits between the keypad/controller logic and the lock's `d_in` pin, on the same clock as the lock.

## Interface
- CODE_LEN, 6: code length in bits, ≥2.
- BIT_CYCLES, 1: clocks each bit is held on `d_out`, ≥1. Must be 1 when driving the lock directly, because the lock samples `d_in` every clock.
- ACK_TIMEOUT, 8: WAIT_ACK cycles allowed for `door_open` before an attempt fails, ≥1.
- MAX_RETRY, 2: extra attempts after the first failure, ≥0.
- Ports (one clock; reset is asynchronous and active-low):
  - clk  in  1  rising-edge clock.
  - reset  in  1  asynchronous active-low reset (0 = reset).
  - start  in  1  request; sampled only in IDLE.
  - code_in  in  CODE_LEN  code to send; latched when start is accepted.
  - door_open  in  1  lock feedback; sampled only in WAIT_ACK.
  - d_out  out  1  serial code, registered; to lock `d_in`.
  - busy  out  1  high in every state except IDLE.
  - done  out  1  one-cycle completion pulse.
  - unlocked  out  1  result; valid with done, held until the next accepted start.

## Operation
- Reset (async, reset=0): state IDLE. `d_out`=0, busy=0, done=0, unlocked=0. All counters 0; the shift register and code latch are cleared. Reset asserted mid-operation aborts immediately; no done pulse is produced.
- Registers:
  - code latch [CODE_LEN]
  - shift reg [CODE_LEN]
  - bit_cnt, 0..CODE_LEN-1
  - cyc_cnt, wide enough for max(BIT_CYCLES, ACK_TIMEOUT, 2*BIT_CYCLES)
  - retry_cnt, 0..MAX_RETRY
- IDLE: `d_out`=0. If start=1, latch code_in into both the code latch and the shift reg, clear all counters and unlocked, and go to SEND. If start=0, stay.
- SEND: `d_out` = shift reg MSB. cyc_cnt counts 0..BIT_CYCLES-1. At BIT_CYCLES-1, shift left and increment bit_cnt. After bit CODE_LEN-1 finishes, go to WAIT_ACK and drive `d_out`=0.
- WAIT_ACK: `d_out`=0; door_open is sampled every cycle, including the first.
  - door_open=1: go to DONE with unlocked=1.
  - ACK_TIMEOUT cycles elapse with door_open=0 and retry_cnt<MAX_RETRY: increment retry_cnt, go to GAP.
  - ACK_TIMEOUT cycles elapse with door_open=0 and retry_cnt=MAX_RETRY: go to DONE with unlocked=0.
  - If door_open=1 in the final timeout cycle, success wins.
- GAP: `d_out`=0 for exactly 2*BIT_CYCLES cycles. Then reload the shift reg from the code latch (not code_in), clear bit_cnt and cyc_cnt, and go to SEND.
- DONE: done=1 for exactly one cycle, busy=1. Go to IDLE.
- start while busy is ignored and is not queued. start high in the DONE cycle is ignored. start held high in IDLE begins a new transaction.
- Changes on code_in after acceptance have no effect, including on retries.

## Timing
- Cycle 0 = the cycle in which start=1 is sampled in IDLE.
- busy=1 from cycle 1 through the DONE cycle inclusive.
- Bit k (k=0 is the MSB) occupies cycles 1+k·BIT_CYCLES .. (k+1)·BIT_CYCLES.
- Let N = CODE_LEN·BIT_CYCLES. WAIT_ACK starts at cycle N+1.
- door_open seen at cycle t → done=1 at cycle t+1, then IDLE at t+2.
- Against the lock with defaults: the last bit is in cycle 6, door_open is high in cycle 7, and done is in cycle 8.
- Each failed attempt costs N + ACK_TIMEOUT + 2·BIT_CYCLES cycles.
- Total failure (defaults): done in cycle 3·6 + 3·8 + 2·2 + 1 = 47.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Test plan
- Defaults, code_in=6'b101010, lock model attached → `d_out` cycles 1–6 = 1,0,1,0,1,0; door_open in cycle 7; done=1, unlocked=1 in cycle 8; busy=0 in cycle 9.
- code_in=6'b110000, door_open tied 0 → three send bursts starting at cycles 1, 17 and 33; `d_out`=0 during the gaps (cycles 15–16, 31–32); done=1, unlocked=0 in cycle 47.
- Retry success: door_open tied 0 for the first attempt, then pulsed at cycle 23 → second burst = the original code; done=1, unlocked=1 in cycle 24.
- start pulsed at cycles 3 and 10, and code_in changed at cycle 2 → no restart, no new latch; the burst matches the code sampled at cycle 0.
- reset=0 asserted asynchronously mid-cycle 4 → `d_out`, busy, done and unlocked go to 0 immediately. After release, a new start yields a full burst from bit 0.
- BIT_CYCLES=3, code 6'b100001 → `d_out` high for cycles 1–3 and 16–18, low otherwise; WAIT_ACK begins at cycle 19.
